// File: rtl/mem_access_stage.sv
// MEM stage of the RV32IM pipeline: request/ready data port, byte/half/word
// alignment, load extension, store lane generation, timeout fault and MEM/WB register.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WRITE_ENABLE,
  input  logic        MEM_ACCESS,
  input  logic        MEM_WRITE,
  input  logic        MEM_READ,
  input  logic [31:0] ALU_OUTPUT,
  input  logic [4:0]  WRITE_ADDRESS,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] DATA2,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BYTE_EN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  input  logic        MEM_READY,
  input  logic [31:0] MEM_RDATA,
  output logic        STALL,
  output logic        WB_WRITE_ENABLE_OUT,
  output logic [4:0]  WB_WRITE_ADDRESS_OUT,
  output logic [31:0] WB_DATA_OUT,
  output logic        FAULT_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       lane_r;
  logic [2:0]       funct3_r;
  logic [31:0]      rdata_r;
  logic             timeout_r;
  logic             mem_req_r, mem_we_r;
  logic [31:0]      mem_addr_r, mem_wdata_r;
  logic [3:0]       mem_byte_en_r;
  logic             wb_we_r, wb_fault_r;
  logic [4:0]       wb_rd_r;
  logic [31:0]      wb_data_r;

  logic             access_s, legal_f3_s, misaligned_s, go_s, bad_s, stall_s;
  logic             wb_we_nxt_s, wb_fault_nxt_s;
  logic [4:0]       wb_rd_nxt_s;
  logic [31:0]      wb_data_nxt_s;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] lane, input logic [2:0] f3);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Decode the EX/MEM access: legality, alignment and whether to issue.
  always_comb begin
    access_s = MEM_ACCESS & (MEM_READ | MEM_WRITE);
    if (MEM_WRITE) begin
      legal_f3_s = (FUNCT3 == 3'b000) | (FUNCT3 == 3'b001) | (FUNCT3 == 3'b010);
    end else begin
      legal_f3_s = (FUNCT3 == 3'b000) | (FUNCT3 == 3'b001) | (FUNCT3 == 3'b010) |
                   (FUNCT3 == 3'b100) | (FUNCT3 == 3'b101);
    end
    misaligned_s = ((FUNCT3[1:0] == 2'b01) & ALU_OUTPUT[0]) |
                   ((FUNCT3[1:0] == 2'b10) & (ALU_OUTPUT[1:0] != 2'b00));
    go_s  = access_s & legal_f3_s & ~misaligned_s;
    bad_s = access_s & ~go_s;
  end

  // Next state, stall and the value the MEM/WB register loads on this edge.
  always_comb begin
    state_nxt_s    = state_r;
    stall_s        = 1'b0;
    wb_we_nxt_s    = 1'b0;
    wb_rd_nxt_s    = 5'd0;
    wb_data_nxt_s  = 32'd0;
    wb_fault_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!access_s) begin
          wb_we_nxt_s   = WRITE_ENABLE;
          wb_rd_nxt_s   = WRITE_ADDRESS;
          wb_data_nxt_s = ALU_OUTPUT;
        end else if (bad_s) begin
          wb_fault_nxt_s = 1'b1;
        end else begin
          stall_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (MEM_READY || (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Upstream is still holding the instruction, so rd/WE come from the inputs.
        state_nxt_s = ST_IDLE;
        if (timeout_r) begin
          wb_fault_nxt_s = 1'b1;
        end else if (mem_we_r) begin
          wb_we_nxt_s = 1'b0;
        end else begin
          wb_we_nxt_s   = WRITE_ENABLE;
          wb_rd_nxt_s   = WRITE_ADDRESS;
          wb_data_nxt_s = rdata_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Request registers, timeout counter and captured load data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= 32'd0;
      mem_wdata_r   <= 32'd0;
      mem_byte_en_r <= 4'd0;
      cnt_r         <= '0;
      lane_r        <= 2'd0;
      funct3_r      <= 3'd0;
      rdata_r       <= 32'd0;
      timeout_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            mem_req_r     <= 1'b1;
            mem_we_r      <= MEM_WRITE;
            mem_addr_r    <= {ALU_OUTPUT[31:2], 2'b00};
            mem_wdata_r   <= MEM_WRITE ? store_lanes(DATA2, FUNCT3) : 32'd0;
            mem_byte_en_r <= lane_enables(ALU_OUTPUT[1:0], FUNCT3);
            cnt_r         <= '0;
            lane_r        <= ALU_OUTPUT[1:0];
            funct3_r      <= FUNCT3;
            timeout_r     <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (MEM_READY) begin
            rdata_r   <= load_extract(MEM_RDATA, lane_r, funct3_r);
            mem_req_r <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            mem_req_r <= 1'b0;
            timeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wb_we_r    <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
      wb_fault_r <= 1'b0;
    end else begin
      wb_we_r    <= wb_we_nxt_s;
      wb_rd_r    <= wb_rd_nxt_s;
      wb_data_r  <= wb_data_nxt_s;
      wb_fault_r <= wb_fault_nxt_s;
    end
  end

  assign MEM_ADDR             = mem_addr_r;
  assign MEM_WDATA            = mem_wdata_r;
  assign MEM_BYTE_EN          = mem_byte_en_r;
  assign MEM_REQ              = mem_req_r;
  assign MEM_WE               = mem_we_r;
  assign STALL                = stall_s;
  assign WB_WRITE_ENABLE_OUT  = wb_we_r;
  assign WB_WRITE_ADDRESS_OUT = wb_rd_r;
  assign WB_DATA_OUT          = wb_data_r;
  assign FAULT_OUT            = wb_fault_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, loads,
// stores, misaligned/illegal faults, delayed ready, timeout and mid-access reset.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WRITE_ENABLE = 1'b0, MEM_ACCESS = 1'b0, MEM_WRITE = 1'b0, MEM_READ = 1'b0;
  logic [31:0] ALU_OUTPUT = 32'd0, DATA2 = 32'd0, MEM_RDATA = 32'd0;
  logic [4:0]  WRITE_ADDRESS = 5'd0;
  logic [2:0]  FUNCT3 = 3'd0;
  logic        MEM_READY = 1'b0;
  logic [31:0] MEM_ADDR, MEM_WDATA, WB_DATA_OUT;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_REQ, MEM_WE, STALL, WB_WRITE_ENABLE_OUT, FAULT_OUT;
  logic [4:0]  WB_WRITE_ADDRESS_OUT;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .WRITE_ENABLE(WRITE_ENABLE), .MEM_ACCESS(MEM_ACCESS),
    .MEM_WRITE(MEM_WRITE), .MEM_READ(MEM_READ), .ALU_OUTPUT(ALU_OUTPUT),
    .WRITE_ADDRESS(WRITE_ADDRESS), .FUNCT3(FUNCT3), .DATA2(DATA2),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BYTE_EN(MEM_BYTE_EN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA),
    .STALL(STALL), .WB_WRITE_ENABLE_OUT(WB_WRITE_ENABLE_OUT),
    .WB_WRITE_ADDRESS_OUT(WB_WRITE_ADDRESS_OUT), .WB_DATA_OUT(WB_DATA_OUT),
    .FAULT_OUT(FAULT_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    MEM_ACCESS = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; WRITE_ENABLE = 1'b0;
    MEM_READY  = 1'b0;
  endtask

  // Issue one memory instruction (called 1 time unit after a rising edge) and
  // follow it through stall, completion and the MEM/WB load.
  task automatic mem_op(input string tag, input logic [2:0] f3, input logic wr,
                        input logic [31:0] addr, input logic [31:0] d2,
                        input logic [31:0] rdata, input int delay, input int exp_stalls,
                        input logic [31:0] exp_data, input logic exp_fault,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int stalls;
    int nbusy;
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    MEM_ACCESS = 1'b1; MEM_WRITE = wr; MEM_READ = ~wr; FUNCT3 = f3;
    ALU_OUTPUT = addr; DATA2 = d2; MEM_RDATA = rdata;
    WRITE_ENABLE = 1'b1; WRITE_ADDRESS = 5'd9; MEM_READY = 1'b0;
    #1;
    stalls = 0;
    nbusy  = 0;
    while (STALL && stalls < 40) begin
      if (MEM_REQ) begin
        check_val({tag, "_addr"}, MEM_ADDR, aligned);
        MEM_READY = (nbusy >= delay);
        nbusy++;
      end
      stalls++;
      @(posedge CLK); #1;
      MEM_READY = 1'b0;
    end
    check_val({tag, "_stalls"}, stalls, exp_stalls);
    check_val({tag, "_req_low"}, {31'd0, MEM_REQ}, 32'd0);
    if (wr && !exp_fault) begin
      check_val({tag, "_we"}, {31'd0, MEM_WE}, 32'd1);
      check_val({tag, "_be"}, {28'd0, MEM_BYTE_EN}, {28'd0, exp_be});
      check_val({tag, "_wdata"}, MEM_WDATA, exp_wdata);
    end
    @(posedge CLK); #1;
    check_val({tag, "_wb_we"}, {31'd0, WB_WRITE_ENABLE_OUT}, {31'd0, (!wr && !exp_fault)});
    check_val({tag, "_fault"}, {31'd0, FAULT_OUT}, {31'd0, exp_fault});
    if (!wr && !exp_fault) begin
      check_val({tag, "_wb_data"}, WB_DATA_OUT, exp_data);
      check_val({tag, "_wb_rd"}, {27'd0, WB_WRITE_ADDRESS_OUT}, 32'd9);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_req",   {31'd0, MEM_REQ}, 32'd0);
    check_val("rst_stall", {31'd0, STALL}, 32'd0);
    check_val("rst_wb_we", {31'd0, WB_WRITE_ENABLE_OUT}, 32'd0);
    check_val("rst_wb_data", WB_DATA_OUT, 32'd0);
    check_val("rst_fault", {31'd0, FAULT_OUT}, 32'd0);
    RESET = 1'b0;

    // Plain ALU instruction passes straight through to MEM/WB.
    WRITE_ENABLE = 1'b1; WRITE_ADDRESS = 5'd5; ALU_OUTPUT = 32'h0000_1234;
    #1;
    check_val("alu_stall", {31'd0, STALL}, 32'd0);
    @(posedge CLK); #1;
    check_val("alu_data", WB_DATA_OUT, 32'h0000_1234);
    check_val("alu_rd", {27'd0, WB_WRITE_ADDRESS_OUT}, 32'd5);
    check_val("alu_we", {31'd0, WB_WRITE_ENABLE_OUT}, 32'd1);
    check_val("alu_fault", {31'd0, FAULT_OUT}, 32'd0);
    idle_inputs();

    mem_op("lb",  3'b000, 1'b0, 32'h103, 32'd0, 32'h80AA_BBCC, 0, 2, 32'hFFFF_FF80, 1'b0, 4'd0, 32'd0);
    mem_op("lbu", 3'b100, 1'b0, 32'h103, 32'd0, 32'h80AA_BBCC, 0, 2, 32'h0000_0080, 1'b0, 4'd0, 32'd0);
    mem_op("sh",  3'b001, 1'b1, 32'h202, 32'hDEAD_BEEF, 32'd0, 0, 2, 32'd0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    mem_op("sb",  3'b000, 1'b1, 32'h001, 32'h0000_00A5, 32'd0, 0, 2, 32'd0, 1'b0, 4'b0010, 32'hA5A5_A5A5);
    mem_op("sw",  3'b010, 1'b1, 32'h010, 32'hCAFE_F00D, 32'd0, 0, 2, 32'd0, 1'b0, 4'b1111, 32'hCAFE_F00D);

    mem_op("lw_mis", 3'b010, 1'b0, 32'h003, 32'd0, 32'd0, 0, 0, 32'd0, 1'b1, 4'd0, 32'd0);
    @(posedge CLK); #1;
    check_val("lw_mis_pulse", {31'd0, FAULT_OUT}, 32'd0);
    mem_op("lh_mis", 3'b001, 1'b0, 32'h005, 32'd0, 32'd0, 0, 0, 32'd0, 1'b1, 4'd0, 32'd0);
    @(posedge CLK); #1;
    check_val("lh_mis_pulse", {31'd0, FAULT_OUT}, 32'd0);
    mem_op("ld_ill", 3'b011, 1'b0, 32'h000, 32'd0, 32'd0, 0, 0, 32'd0, 1'b1, 4'd0, 32'd0);

    mem_op("lw_dly", 3'b010, 1'b0, 32'h040, 32'd0, 32'h1234_5678, 4, 6, 32'h1234_5678, 1'b0, 4'd0, 32'd0);
    mem_op("lw_tmo", 3'b010, 1'b0, 32'h080, 32'd0, 32'h5555_5555, 1000, 17, 32'd0, 1'b1, 4'd0, 32'd0);

    // Reset while the memory is still busy abandons the access.
    MEM_ACCESS = 1'b1; MEM_READ = 1'b1; FUNCT3 = 3'b010; ALU_OUTPUT = 32'h020;
    WRITE_ENABLE = 1'b1; WRITE_ADDRESS = 5'd3;
    @(posedge CLK); #1;
    check_val("rb_req", {31'd0, MEM_REQ}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check_val("rb_req_low", {31'd0, MEM_REQ}, 32'd0);
    check_val("rb_wb_we", {31'd0, WB_WRITE_ENABLE_OUT}, 32'd0);
    check_val("rb_wb_data", WB_DATA_OUT, 32'd0);
    check_val("rb_fault", {31'd0, FAULT_OUT}, 32'd0);
    RESET = 1'b0;
    idle_inputs();
    #1;
    check_val("rb_stall", {31'd0, STALL}, 32'd0);
    @(posedge CLK); #1;

    mem_op("lh",  3'b001, 1'b0, 32'h106, 32'd0, 32'h8001_7FFF, 0, 2, 32'hFFFF_8001, 1'b0, 4'd0, 32'd0);
    mem_op("lhu", 3'b101, 1'b0, 32'h104, 32'd0, 32'h8001_7FFF, 1, 3, 32'h0000_7FFF, 1'b0, 4'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
